// File: rtl/sq_gen_pkg.sv
// Shared state encoding and default sizing for the programmable square-wave generator.
package sq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_FREQ_W   = 32;
  localparam int unsigned DEF_ACC_W    = 34;

  // Highest representable output frequency: one toggle per clock.
  localparam int unsigned DEF_F_MAX    = DEF_CLK_FREQ / 2;

endpackage

// File: rtl/sq_gen_accum.sv
// Modulus (Bresenham) accumulator: toggles sig_out 2*f_act times per CLK_FREQ cycles
// and reports the rising/falling edge in the same cycle sig_out changes.
module sq_gen_accum #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned FREQ_W   = 32,
  parameter int unsigned ACC_W    = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [FREQ_W-1:0] f_act,
  output logic              sig_out,
  output logic              rise,
  output logic              fall
);

  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_FREQ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;
  logic             wrap;

  always_comb begin
    nxt  = acc + (ACC_W'(f_act) << 1);
    wrap = (nxt >= MODULUS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      sig_out <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      sig_out <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= en & wrap & ~sig_out;
      fall <= en & wrap & sig_out;
      if (en) begin
        if (wrap) begin
          acc     <= nxt - MODULUS;
          sig_out <= ~sig_out;
        end else begin
          acc <= nxt;
        end
      end
    end
  end

endmodule

// File: rtl/sq_wave_gen.sv
// Programmable square-wave generator: config handshake, pending update register,
// burst counting and the IDLE/RUN/DRAIN sequencing around the accumulator.
module sq_wave_gen
  import sq_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned FREQ_W   = DEF_FREQ_W,
  parameter int unsigned ACC_W    = DEF_ACC_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [FREQ_W-1:0] cfg_freq,
  input  logic [FREQ_W-1:0] cfg_burst_len,
  input  logic              start,
  input  logic              stop,
  output logic              sig_out,
  output logic              rise_stb,
  output logic              busy,
  output logic              done
);

  localparam logic [FREQ_W-1:0] F_MAX = FREQ_W'(CLK_FREQ / 2);
  localparam logic [FREQ_W-1:0] ONE   = FREQ_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [FREQ_W-1:0] freq_act;
  logic [FREQ_W-1:0] burst_len;
  logic [FREQ_W-1:0] pend_freq;
  logic [FREQ_W-1:0] pend_burst;
  logic [FREQ_W-1:0] rise_cnt;
  logic [FREQ_W-1:0] f_use;
  logic [FREQ_W-1:0] f_clamped;
  logic              pend_valid;
  logic              pend_burst_valid;
  logic              cfg_fire;
  logic              apply_pend;
  logic              burst_hit;
  logic              rise;
  logic              fall;
  logic              accum_clear;
  logic              accum_en;

  // A pending frequency takes effect on the very accumulation of its rise cycle,
  // so the switch lands on a phase-continuous edge with no runt half-period.
  always_comb begin
    f_clamped  = (cfg_freq > F_MAX) ? F_MAX : cfg_freq;
    cfg_ready  = (state == IDLE) || !pend_valid;
    cfg_fire   = cfg_valid && cfg_ready;
    rise_stb   = rise && (state == RUN);
    apply_pend = rise_stb && pend_valid;
    f_use      = apply_pend ? pend_freq : freq_act;
    burst_hit  = rise_stb && (burst_len != '0) && ((rise_cnt + ONE) == burst_len);
    busy       = (state != IDLE);
  end

  // Stopping while low must not let the accumulator start a new high half.
  always_comb begin
    state_nxt   = state;
    accum_en    = 1'b0;
    accum_clear = 1'b0;
    case (state)
      IDLE: begin
        accum_clear = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        accum_en = !(stop && !sig_out);
        if (stop || burst_hit) state_nxt = DRAIN;
      end
      DRAIN: begin
        accum_en = sig_out;
        if (fall || !sig_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      done             <= 1'b0;
      freq_act         <= '0;
      burst_len        <= '0;
      pend_freq        <= '0;
      pend_burst       <= '0;
      pend_valid       <= 1'b0;
      pend_burst_valid <= 1'b0;
      rise_cnt         <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && (state_nxt == IDLE);
      if (state == IDLE) begin
        rise_cnt         <= '0;
        pend_valid       <= 1'b0;
        pend_burst_valid <= 1'b0;
        if (cfg_fire) begin
          freq_act  <= f_clamped;
          burst_len <= cfg_burst_len;
        end else begin
          if (pend_valid) freq_act <= pend_freq;
          if (pend_burst_valid) burst_len <= pend_burst;
        end
      end else begin
        freq_act <= f_use;
        if (rise_stb) rise_cnt <= rise_cnt + ONE;
        if (apply_pend) begin
          pend_valid <= 1'b0;
        end else if (cfg_fire) begin
          pend_valid       <= 1'b1;
          pend_burst_valid <= 1'b1;
          pend_freq        <= f_clamped;
          pend_burst       <= cfg_burst_len;
        end
      end
    end
  end

  sq_gen_accum #(
    .CLK_FREQ(CLK_FREQ),
    .FREQ_W  (FREQ_W),
    .ACC_W   (ACC_W)
  ) u_accum (
    .clk    (sys_clk),
    .rst    (rst),
    .clear  (accum_clear),
    .en     (accum_en),
    .f_act  (f_use),
    .sig_out(sig_out),
    .rise   (rise),
    .fall   (fall)
  );

endmodule

// File: tb/tb_sq_wave_gen.sv
// Directed scoreboard bench for sq_wave_gen with CLK_FREQ=100: expectations are
// queued before each scenario and popped as the measured results come in.
module tb_sq_wave_gen;

  localparam int unsigned CLK_FREQ = 100;
  localparam int unsigned FREQ_W   = 32;
  localparam int unsigned ACC_W    = 34;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    int rises;
    int toggles;
    int highs;
    int busy_low;
    int rp_min;
    int rp_max;
    int run_min;
    int run_max;
  } obs_t;

  typedef struct {
    int fall_tick;
    int done_tick;
    int rises;
    int toggles;
    int busy_at_done;
    int sig_at_done;
  } drain_t;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [FREQ_W-1:0] cfg_freq;
  logic [FREQ_W-1:0] cfg_burst_len;
  logic              start;
  logic              stop;
  logic              sig_out;
  logic              rise_stb;
  logic              busy;
  logic              done;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sq_wave_gen #(
    .CLK_FREQ(CLK_FREQ),
    .FREQ_W  (FREQ_W),
    .ACC_W   (ACC_W)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_freq     (cfg_freq),
    .cfg_burst_len(cfg_burst_len),
    .start        (start),
    .stop         (stop),
    .sig_out      (sig_out),
    .rise_stb     (rise_stb),
    .busy         (busy),
    .done         (done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("[TB] FAIL scoreboard_empty: observed %0d, expected nothing queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
    end
  endtask

  // One-cycle pulse of the config/start/stop inputs.
  task automatic apply_stimulus(input logic v, input int f, input int b, input logic st,
                                input logic sp);
    cfg_valid     = v;
    cfg_freq      = FREQ_W'(f);
    cfg_burst_len = FREQ_W'(b);
    start         = st;
    stop          = sp;
    tick();
    cfg_valid     = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
  endtask

  task automatic wait_rise(input int max_ticks, output int ticks);
    ticks = max_ticks + 1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (rise_stb) begin
        ticks = i;
        break;
      end
    end
  endtask

  // Run lengths exclude the partial run that was already in progress at window start.
  task automatic observe(input int n, output obs_t o);
    logic prev;
    int   run_len;
    int   runs_seen;
    int   last_rise;
    o         = '{default: 0};
    o.rp_min  = 1_000_000;
    o.run_min = 1_000_000;
    prev      = sig_out;
    run_len   = 0;
    runs_seen = 0;
    last_rise = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (rise_stb) begin
        o.rises++;
        if (last_rise >= 0) begin
          if (i - last_rise < o.rp_min) o.rp_min = i - last_rise;
          if (i - last_rise > o.rp_max) o.rp_max = i - last_rise;
        end
        last_rise = i;
      end
      if (sig_out !== prev) begin
        o.toggles++;
        if (runs_seen > 0) begin
          if (run_len < o.run_min) o.run_min = run_len;
          if (run_len > o.run_max) o.run_max = run_len;
        end
        runs_seen++;
        run_len = 1;
        prev    = sig_out;
      end else begin
        run_len++;
      end
      if (sig_out === 1'b1) o.highs++;
      if (busy !== 1'b1) o.busy_low++;
    end
  endtask

  task automatic wait_done(input logic with_stop, input int max_ticks, output drain_t d);
    logic prev;
    d           = '{default: 0};
    d.done_tick = max_ticks + 1;
    prev        = sig_out;
    if (with_stop) stop = 1'b1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      stop = 1'b0;
      if (rise_stb) d.rises++;
      if (sig_out !== prev) begin
        d.toggles++;
        if (sig_out === 1'b0) d.fall_tick = i;
        prev = sig_out;
      end
      if (done === 1'b1) begin
        d.done_tick    = i;
        d.busy_at_done = int'(busy);
        d.sig_at_done  = int'(sig_out);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    obs_t   o;
    drain_t d;
    int     t;
    int     ready_high;

    rst           = 1'b1;
    cfg_valid     = 1'b0;
    cfg_freq      = '0;
    cfg_burst_len = '0;
    start         = 1'b0;
    stop          = 1'b0;

    push_exp("rst_sig_out", 0);
    push_exp("rst_rise_stb", 0);
    push_exp("rst_busy", 0);
    push_exp("rst_done", 0);
    push_exp("rst_cfg_ready", 1);
    #12;
    check_output(sig_out);
    check_output(rise_stb);
    check_output(busy);
    check_output(done);
    check_output(cfg_ready);
    rst = 1'b0;
    tick();

    $display("[TB] scenario 1: f=10 continuous, then stop while high");
    push_exp("s1_busy", 1);
    push_exp("s1_first_rise", 5);
    push_exp("s1_rises", 10);
    push_exp("s1_highs", 50);
    push_exp("s1_rise_period_min", 10);
    push_exp("s1_rise_period_max", 10);
    push_exp("s1_busy_low", 0);
    push_exp("s1_fall_tick", 5);
    push_exp("s1_done_tick", 6);
    push_exp("s1_drain_rises", 0);
    push_exp("s1_done_busy", 0);
    push_exp("s1_done_sig", 0);
    push_exp("s1_done_width", 0);
    apply_stimulus(1'b1, 10, 0, 1'b1, 1'b0);
    check_output(busy);
    wait_rise(20, t);
    check_output(t);
    observe(100, o);
    check_output(o.rises);
    check_output(o.highs);
    check_output(o.rp_min);
    check_output(o.rp_max);
    check_output(o.busy_low);
    wait_done(1'b1, 50, d);
    check_output(d.fall_tick);
    check_output(d.done_tick);
    check_output(d.rises);
    check_output(d.busy_at_done);
    check_output(d.sig_at_done);
    tick();
    check_output(done);

    $display("[TB] scenario 2: f=3 continuous, then stop while low");
    push_exp("s2_rises", 3);
    push_exp("s2_toggles", 6);
    push_exp("s2_run_min", 16);
    push_exp("s2_run_max", 17);
    push_exp("s2_done_tick", 2);
    push_exp("s2_drain_toggles", 0);
    apply_stimulus(1'b1, 3, 0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
    observe(100, o);
    check_output(o.rises);
    check_output(o.toggles);
    check_output(o.run_min);
    check_output(o.run_max);
    wait_done(1'b1, 50, d);
    check_output(d.done_tick);
    check_output(d.toggles);

    $display("[TB] scenario 3: f=10 burst of 4");
    push_exp("s3_rises", 4);
    push_exp("s3_toggles", 8);
    push_exp("s3_fall_tick", 40);
    push_exp("s3_done_tick", 41);
    push_exp("s3_done_busy", 0);
    push_exp("s3_done_sig", 0);
    push_exp("s3_done_width", 0);
    push_exp("s3_idle_toggles", 0);
    push_exp("s3_idle_busy_low", 20);
    apply_stimulus(1'b1, 10, 4, 1'b1, 1'b0);
    wait_done(1'b0, 80, d);
    check_output(d.rises);
    check_output(d.toggles);
    check_output(d.fall_tick);
    check_output(d.done_tick);
    check_output(d.busy_at_done);
    check_output(d.sig_at_done);
    tick();
    check_output(done);
    observe(20, o);
    check_output(o.toggles);
    check_output(o.busy_low);

    $display("[TB] scenario 4: clamp f=70 with start+stop together in idle");
    push_exp("s4_busy", 1);
    push_exp("s4_first_rise", 1);
    push_exp("s4_toggles", 19);
    push_exp("s4_rises", 9);
    push_exp("s4_rise_period_min", 2);
    push_exp("s4_rise_period_max", 2);
    push_exp("s4_run_max", 1);
    push_exp("s4_done_tick", 2);
    push_exp("s4_drain_toggles", 0);
    push_exp("s4_drain_rises", 0);
    apply_stimulus(1'b1, 70, 0, 1'b1, 1'b1);
    check_output(busy);
    wait_rise(20, t);
    check_output(t);
    observe(19, o);
    check_output(o.toggles);
    check_output(o.rises);
    check_output(o.rp_min);
    check_output(o.rp_max);
    check_output(o.run_max);
    wait_done(1'b1, 20, d);
    check_output(d.done_tick);
    check_output(d.toggles);
    check_output(d.rises);

    $display("[TB] scenario 5: mid-run update from f=10 to f=25");
    push_exp("s5_first_rise", 5);
    push_exp("s5_ready_after_offer", 0);
    push_exp("s5_ticks_to_switch_rise", 9);
    push_exp("s5_ready_before_rise", 0);
    push_exp("s5_ready_after_rise", 1);
    push_exp("s5_switch_period", 4);
    push_exp("s5_rises", 10);
    push_exp("s5_rise_period_min", 4);
    push_exp("s5_rise_period_max", 4);
    push_exp("s5_run_min", 2);
    push_exp("s5_run_max", 2);
    apply_stimulus(1'b1, 10, 0, 1'b1, 1'b0);
    wait_rise(20, t);
    check_output(t);
    apply_stimulus(1'b1, 25, 0, 1'b0, 1'b0);
    check_output(cfg_ready);
    ready_high = 0;
    t          = 31;
    for (int i = 0; i <= 30; i++) begin
      if (rise_stb) begin
        t = i;
        break;
      end
      if (cfg_ready !== 1'b0) ready_high++;
      tick();
    end
    check_output(t);
    check_output(ready_high);
    tick();
    check_output(cfg_ready);
    wait_rise(20, t);
    check_output(1 + t);
    observe(40, o);
    check_output(o.rises);
    check_output(o.rp_min);
    check_output(o.rp_max);
    check_output(o.run_min);
    check_output(o.run_max);

    $display("[TB] scenario 6: asynchronous reset mid-run drops pending config");
    push_exp("s6_ready_with_pending", 0);
    push_exp("s6_high_before_reset", 1);
    push_exp("s6_rst_sig_out", 0);
    push_exp("s6_rst_busy", 0);
    push_exp("s6_rst_cfg_ready", 1);
    push_exp("s6_restart_busy_low", 0);
    push_exp("s6_restart_toggles", 0);
    push_exp("s6_stop_done_tick", 2);
    apply_stimulus(1'b1, 10, 0, 1'b0, 1'b0);
    check_output(cfg_ready);
    for (int i = 0; i < 10; i++) begin
      if (sig_out === 1'b1) break;
      tick();
    end
    check_output(sig_out);
    #2;
    rst = 1'b1;
    #1;
    check_output(sig_out);
    check_output(busy);
    check_output(cfg_ready);
    #3;
    rst = 1'b0;
    tick();
    apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
    observe(30, o);
    check_output(o.busy_low);
    check_output(o.toggles);
    wait_done(1'b1, 20, d);
    check_output(d.done_tick);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
